adc_frame_align: RTL and testbench
==================================

# adc_frame_align

Bit-alignment controller for one ADC LVDS link, sitting directly downstream of the 1:8 DDR deserializer. Each divided-clock cycle it inspects the deserialized 8-bit word of the ADC frame-clock lane against the expected frame pattern. It issues single-cycle BITSLIP pulses back to the deserializers until the pattern is stable, then reports lock. Data lanes share the same BITSLIP, so alignment of the frame lane aligns the whole link.

## Interface
- FRAME_PATTERN, 8'hF0, expected deserialized frame-lane word when aligned
- MATCH_COUNT, 16, consecutive matching words required to declare lock (2..255)
- LOSS_COUNT, 4, consecutive mismatching words in LOCKED that drop lock (1..15)
- SETTLE_CYCLES, 4, cycles ignored after each BITSLIP while the deserializer output settles (1..15)
- MAX_SLIPS, 8, BITSLIP pulses attempted before declaring failure (1..15)

- CLKDIV  in  1  divided clock; the only clock; same clock driving the deserializer CLKDIV
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  alignment enable; level-sensitive
- FRAME_Q  in  8  deserialized frame-lane word (Q[7:0] of the frame-lane deserializer)
- BITSLIP  out  1  one-cycle pulse to all deserializer BITSLIP inputs of the link
- ALIGNED  out  1  high while locked
- ALIGN_ERR  out  1  high when MAX_SLIPS exhausted without lock
- SLIP_CNT  out  4  BITSLIP pulses issued in current acquisition

## Operation
- FSM states: IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL. Internal counters: match_cnt (8b), loss_cnt (4b), settle_cnt (4b), slip_cnt (4b, drives SLIP_CNT).
- IDLE: all counters cleared. EN=1 -> CHECK.
- CHECK: FRAME_Q==FRAME_PATTERN -> match_cnt+1; match_cnt reaching MATCH_COUNT -> LOCKED. Mismatch -> match_cnt=0; if slip_cnt==MAX_SLIPS -> FAIL, else -> SLIP.
- SLIP: one cycle only; BITSLIP=1; slip_cnt+1; -> SETTLE with settle_cnt=0.
- SETTLE: FRAME_Q ignored; after SETTLE_CYCLES cycles -> CHECK with match_cnt=0.
- LOCKED: mismatch -> loss_cnt+1; match -> loss_cnt=0; loss_cnt reaching LOSS_COUNT -> CHECK, with slip_cnt, match_cnt, loss_cnt cleared (fresh acquisition).
- FAIL: ALIGN_ERR=1; holds until EN=0.
- EN=0 in any state -> IDLE next edge, overriding all other transitions. A BITSLIP already high in the current cycle is not cancelled. It is never issued after EN samples low.
- Outputs are Moore, decoded from registered state: BITSLIP=(state==SLIP), ALIGNED=(state==LOCKED), ALIGN_ERR=(state==FAIL).
- SLIP_CNT never exceeds MAX_SLIPS. It holds its value in LOCKED and FAIL and clears on IDLE or loss of lock.

## Timing
- Reset (RST_N low, asynchronous, no clock needed): state=IDLE, BITSLIP=0, ALIGNED=0, ALIGN_ERR=0, SLIP_CNT=0, all counters 0. Release is sampled on the next CLKDIV rising edge.
- IDLE with EN=1 at edge k -> CHECK from cycle k+1.
- Lock latency: CHECK entered at cycle N with all words matching -> ALIGNED high from cycle N+MATCH_COUNT.
- Mismatch in CHECK at cycle N -> BITSLIP high in cycle N+1 only -> SETTLE cycles N+2..N+1+SETTLE_CYCLES -> CHECK at N+2+SETTLE_CYCLES.
- Minimum BITSLIP pulse spacing: SETTLE_CYCLES+2 cycles (defaults: 6).
- Loss: LOSS_COUNT-th consecutive mismatch in LOCKED at cycle M -> ALIGNED low from M+1, CHECK at M+1.
- FAIL entered at cycle after mismatch with slip_cnt==MAX_SLIPS. EN low at edge j -> ALIGN_ERR low from j+1.

## Test plan
- Pre-aligned: RST_N released, EN=1, FRAME_Q held 8'hF0 -> no BITSLIP, ALIGNED rises exactly 16 cycles after CHECK entry, SLIP_CNT=0.
- Misaligned: bench deserializer model rotates word per BITSLIP, starting 3 slips away from 8'hF0 -> exactly 3 BITSLIP pulses spaced 6 cycles, ALIGNED asserted, SLIP_CNT=3.
- No pattern: FRAME_Q held 8'h00 -> 8 BITSLIP pulses, then ALIGN_ERR=1, ALIGNED=0, SLIP_CNT=8. EN=0 -> IDLE, ALIGN_ERR=0 next cycle, SLIP_CNT=0.
- Lock hysteresis: in LOCKED, 3 mismatches then 1 match, repeated -> ALIGNED stays 1. Then 4 consecutive mismatches -> ALIGNED falls next cycle and reacquisition restarts with SLIP_CNT=0.
- Async reset mid-SETTLE: RST_N low between clock edges -> all outputs 0 immediately. After release with EN=1, a fresh acquisition starts from IDLE.
- EN drop in CHECK with match_cnt=10 -> IDLE, no BITSLIP. EN reasserted -> lock requires the full 16 matches again.

Source files
------------

// File: rtl/adc_frame_align.sv
// Frame-lane bit alignment: pulses BITSLIP until FRAME_Q shows the frame pattern steadily, then holds ALIGNED.
// Outputs are Moore decodes of registered state; one decision per CLKDIV cycle, no backpressure.
module adc_frame_align #(
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
    parameter int unsigned MATCH_COUNT   = 16,
    parameter int unsigned LOSS_COUNT    = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MAX_SLIPS     = 8
) (
    input  logic       CLKDIV,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [7:0] FRAME_Q,
    output logic       BITSLIP,
    output logic       ALIGNED,
    output logic       ALIGN_ERR,
    output logic [3:0] SLIP_CNT
);

    localparam logic [7:0] MATCH_LIM  = 8'(MATCH_COUNT);
    localparam logic [3:0] LOSS_LIM   = 4'(LOSS_COUNT);
    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SLIP_LIM   = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [3:0] loss_cnt_q, loss_cnt_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    logic       frame_ok;

    assign frame_ok = (FRAME_Q == FRAME_PATTERN);

    always_ff @(posedge CLKDIV or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            match_cnt_q  <= 8'd0;
            loss_cnt_q   <= 4'd0;
            settle_cnt_q <= 4'd0;
            slip_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        settle_cnt_d = settle_cnt_q;
        slip_cnt_d   = slip_cnt_q;

        case (state_q)
            ST_IDLE: begin
                match_cnt_d  = 8'd0;
                loss_cnt_d   = 4'd0;
                settle_cnt_d = 4'd0;
                slip_cnt_d   = 4'd0;
                if (EN) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (frame_ok) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                    if (match_cnt_d == MATCH_LIM) begin
                        state_d    = ST_LOCKED;
                        loss_cnt_d = 4'd0;
                    end
                end else begin
                    match_cnt_d = 8'd0;
                    // The slip budget is spent only once the last slip position also failed.
                    if (slip_cnt_q == SLIP_LIM) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
            end
            ST_SLIP: begin
                slip_cnt_d   = slip_cnt_q + 4'd1;
                settle_cnt_d = 4'd0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LIM) begin
                    settle_cnt_d = 4'd0;
                    match_cnt_d  = 8'd0;
                    state_d      = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            ST_LOCKED: begin
                if (frame_ok) begin
                    loss_cnt_d = 4'd0;
                end else begin
                    loss_cnt_d = loss_cnt_q + 4'd1;
                    // Lock loss restarts acquisition from scratch, including the slip budget.
                    if (loss_cnt_d == LOSS_LIM) begin
                        state_d     = ST_CHECK;
                        loss_cnt_d  = 4'd0;
                        match_cnt_d = 8'd0;
                        slip_cnt_d  = 4'd0;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!EN) begin
            state_d      = ST_IDLE;
            match_cnt_d  = 8'd0;
            loss_cnt_d   = 4'd0;
            settle_cnt_d = 4'd0;
            slip_cnt_d   = 4'd0;
        end
    end

    assign BITSLIP   = (state_q == ST_SLIP);
    assign ALIGNED   = (state_q == ST_LOCKED);
    assign ALIGN_ERR = (state_q == ST_FAIL);
    assign SLIP_CNT  = slip_cnt_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align with a rotating-deserializer model on the frame lane.
module tb_adc_frame_align;

    localparam logic [7:0] PAT = 8'hF0;

    logic       CLKDIV = 1'b0;
    logic       RST_N;
    logic       EN;
    logic [7:0] FRAME_Q;
    logic       BITSLIP;
    logic       ALIGNED;
    logic       ALIGN_ERR;
    logic [3:0] SLIP_CNT;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_val;
    logic       use_model;
    logic       load_mis;
    int         mis_init;
    int         misalign;
    int         slip_at[$];
    int         n;

    always #5 CLKDIV = ~CLKDIV;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Deserializer model: each BITSLIP moves the word one bit closer to alignment.
    always @(posedge CLKDIV) begin
        if (load_mis) misalign <= mis_init;
        else if (BITSLIP) misalign <= (misalign + 7) % 8;
    end

    assign FRAME_Q = use_model ? rotl(PAT, misalign) : frame_val;

    adc_frame_align dut (
        .CLKDIV    (CLKDIV),
        .RST_N     (RST_N),
        .EN        (EN),
        .FRAME_Q   (FRAME_Q),
        .BITSLIP   (BITSLIP),
        .ALIGNED   (ALIGNED),
        .ALIGN_ERR (ALIGN_ERR),
        .SLIP_CNT  (SLIP_CNT)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLKDIV);
    endtask

    function automatic int slip_time(input int idx);
        if (idx < slip_at.size()) return slip_at[idx];
        return -1;
    endfunction

    // Counts negedges until ALIGNED (or ALIGN_ERR) is seen, logging BITSLIP cycles.
    task automatic run_until(input bit want_err, input int budget, output int cyc);
        cyc = 0;
        slip_at.delete();
        while (cyc < budget) begin
            @(negedge CLKDIV);
            cyc++;
            if (BITSLIP) slip_at.push_back(cyc);
            if (want_err ? ALIGN_ERR : ALIGNED) break;
        end
    endtask

    task automatic restart();
        EN = 1'b0;
        step();
    endtask

    initial begin
        RST_N     = 1'b0;
        EN        = 1'b0;
        frame_val = PAT;
        use_model = 1'b0;
        load_mis  = 1'b0;
        mis_init  = 0;

        #1;
        chk("rst_bitslip", int'(BITSLIP), 0);
        chk("rst_aligned", int'(ALIGNED), 0);
        chk("rst_err", int'(ALIGN_ERR), 0);
        chk("rst_slipcnt", int'(SLIP_CNT), 0);
        EN = 1'b1;
        repeat (3) step();
        chk("rst_hold_aligned", int'(ALIGNED), 0);
        chk("rst_hold_bitslip", int'(BITSLIP), 0);

        // Pre-aligned link
        RST_N = 1'b1;
        run_until(1'b0, 100, n);
        chk("pre_lock_cycles", n, 17);
        chk("pre_slips", slip_at.size(), 0);
        chk("pre_slipcnt", int'(SLIP_CNT), 0);

        // Misaligned by three bit positions
        EN        = 1'b0;
        load_mis  = 1'b1;
        mis_init  = 3;
        use_model = 1'b1;
        step();
        load_mis = 1'b0;
        EN       = 1'b1;
        run_until(1'b0, 200, n);
        chk("mis_lock_cycles", n, 35);
        chk("mis_slips", slip_at.size(), 3);
        chk("mis_first_slip", slip_time(0), 2);
        chk("mis_spacing1", slip_time(1) - slip_time(0), 6);
        chk("mis_spacing2", slip_time(2) - slip_time(1), 6);
        chk("mis_slipcnt", int'(SLIP_CNT), 3);
        chk("mis_err", int'(ALIGN_ERR), 0);

        // Lock hysteresis: three misses then a hit never drops lock
        use_model = 1'b0;
        frame_val = PAT;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                frame_val = 8'h00;
                step();
                chk("hyst_miss_hold", int'(ALIGNED), 1);
            end
            frame_val = PAT;
            step();
            chk("hyst_match_hold", int'(ALIGNED), 1);
        end
        frame_val = 8'h00;
        repeat (3) step();
        chk("loss_third_miss", int'(ALIGNED), 1);
        chk("loss_slipcnt_held", int'(SLIP_CNT), 3);
        step();
        chk("loss_fourth_miss", int'(ALIGNED), 0);
        chk("loss_slipcnt_clr", int'(SLIP_CNT), 0);
        step();
        chk("loss_reacq_slip", int'(BITSLIP), 1);

        // No frame pattern at all
        restart();
        frame_val = 8'h00;
        EN        = 1'b1;
        run_until(1'b1, 300, n);
        chk("nopat_fail_cycle", n, 50);
        chk("nopat_slips", slip_at.size(), 8);
        chk("nopat_last_slip", slip_time(7), 44);
        chk("nopat_aligned", int'(ALIGNED), 0);
        chk("nopat_slipcnt", int'(SLIP_CNT), 8);
        repeat (3) step();
        chk("fail_hold_err", int'(ALIGN_ERR), 1);
        chk("fail_no_bitslip", int'(BITSLIP), 0);
        chk("fail_hold_slipcnt", int'(SLIP_CNT), 8);
        EN = 1'b0;
        step();
        chk("fail_clear_err", int'(ALIGN_ERR), 0);
        chk("fail_clear_slipcnt", int'(SLIP_CNT), 0);

        // Enable drop part-way through matching
        frame_val = PAT;
        EN        = 1'b1;
        repeat (11) step();
        chk("endrop_pre_aligned", int'(ALIGNED), 0);
        EN = 1'b0;
        step();
        chk("endrop_bitslip", int'(BITSLIP), 0);
        chk("endrop_aligned", int'(ALIGNED), 0);
        EN = 1'b1;
        run_until(1'b0, 100, n);
        chk("endrop_relock_cycles", n, 17);
        chk("endrop_slips", slip_at.size(), 0);

        // Asynchronous reset while settling
        restart();
        frame_val = 8'h00;
        EN        = 1'b1;
        repeat (4) step();
        chk("settle_slipcnt", int'(SLIP_CNT), 1);
        chk("settle_bitslip", int'(BITSLIP), 0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_slipcnt", int'(SLIP_CNT), 0);
        chk("arst_bitslip", int'(BITSLIP), 0);
        chk("arst_aligned", int'(ALIGNED), 0);
        chk("arst_err", int'(ALIGN_ERR), 0);
        step();
        step();
        frame_val = PAT;
        RST_N     = 1'b1;
        run_until(1'b0, 100, n);
        chk("arst_relock_cycles", n, 17);
        chk("arst_relock_slips", slip_at.size(), 0);
        chk("arst_relock_slipcnt", int'(SLIP_CNT), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
